alu_result_capture: RTL and testbench

//  Registered output stage directly downstream of the combinational 128-bit ALU.
//  - Captures each accepted ALU result, its opcode and its four flags into a DEPTH-entry FIFO.
//  - Presents the FIFO head to the writeback consumer over valid/ready.
//  - Keeps sticky flag accumulators and a retired-result counter for status readout.

---
 rtl/alu_result_capture.sv | 86 ++++++++
 tb/tb_alu_result_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_capture.sv
// Registered output stage for the 128-bit ALU. Accepted results go into a small FIFO,
// and the head is presented over valid/ready. Sticky flags and a retired counter are kept for status.
module alu_result_capture #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_opcode,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    input  logic             clear_sticky,
    output logic [3:0]       sticky_flags,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_mem_op  [DEPTH];
    logic [WIDTH-1:0] r_mem_res [DEPTH];
    logic [3:0]       r_mem_fl  [DEPTH];

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wr_ptr ^ r_rd_ptr) == FULL_XOR;
    assign w_empty = r_wr_ptr == r_rd_ptr;
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign out_opcode = w_empty ? '0 : r_mem_op[r_rd_ptr[AW-1:0]];
    assign out_result = w_empty ? '0 : r_mem_res[r_rd_ptr[AW-1:0]];
    assign out_flags  = w_empty ? '0 : r_mem_fl[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr[AW-1:0]]  <= in_opcode;
            r_mem_res[r_wr_ptr[AW-1:0]] <= in_result;
            r_mem_fl[r_wr_ptr[AW-1:0]]  <= in_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            sticky_flags <= '0;
            retired_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                retired_cnt <= retired_cnt + CNT_ONE;
            end
            if (clear_sticky && w_push) begin
                sticky_flags <= in_flags;
            end else if (clear_sticky) begin
                sticky_flags <= '0;
            end else if (w_push) begin
                sticky_flags <= sticky_flags | in_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_capture.sv
// Self-checking bench for alu_result_capture: directed vector table, hand-written corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_alu_result_capture;

    localparam int WIDTH = 128;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_opcode = '0;
    logic [WIDTH-1:0] in_result = '0;
    logic [3:0]       in_flags = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_opcode;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             clear_sticky = 1'b0;
    logic [3:0]       sticky_flags;
    logic [CNT_W-1:0] retired_cnt;

    alu_result_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_result(in_result), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_result(out_result), .out_flags(out_flags),
        .clear_sticky(clear_sticky), .sticky_flags(sticky_flags),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] res;
        logic [3:0]       fl;
    } ent_t;

    typedef struct {
        logic             iv;
        logic [3:0]       op;
        logic [WIDTH-1:0] res;
        logic [3:0]       fl;
        logic             ordy;
        logic             clr;
        logic             e_valid;
        logic             e_ready;
        logic [3:0]       e_op;
        logic [WIDTH-1:0] e_res;
        logic [3:0]       e_fl;
        logic [3:0]       e_sticky;
        logic [3:0]       e_cnt;
    } vec_t;

    ent_t q[$];
    int unsigned m_cnt = 0;
    logic [3:0] m_sticky = '0;
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock: drive at negedge, advance the model with the accept rules, settle past posedge.
    task automatic cycle(input logic iv, input logic [3:0] op, input logic [WIDTH-1:0] res,
                         input logic [3:0] fl, input logic ordy, input logic clr);
        bit m_push;
        bit m_pop;
        ent_t e;
        @(negedge clk);
        in_valid = iv; in_opcode = op; in_result = res; in_flags = fl;
        out_ready = ordy; clear_sticky = clr;
        m_push = iv && (q.size() < DEPTH);
        m_pop  = ordy && (q.size() != 0);
        @(posedge clk);
        #1;
        if (m_pop) begin
            void'(q.pop_front());
            m_cnt++;
        end
        if (m_push) begin
            e.op = op; e.res = res; e.fl = fl;
            q.push_back(e);
        end
        if (clr && m_push) m_sticky = fl;
        else if (clr) m_sticky = '0;
        else if (m_push) m_sticky = m_sticky | fl;
    endtask

    task automatic check_model(input string tag);
        ent_t h;
        h.op = '0; h.res = '0; h.fl = '0;
        if (q.size() != 0) h = q[0];
        chk({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(q.size() != 0));
        chk({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(q.size() < DEPTH));
        chk({tag, ".out_opcode"}, WIDTH'(out_opcode), WIDTH'(h.op));
        chk({tag, ".out_result"}, out_result, h.res);
        chk({tag, ".out_flags"}, WIDTH'(out_flags), WIDTH'(h.fl));
        chk({tag, ".sticky"}, WIDTH'(sticky_flags), WIDTH'(m_sticky));
        chk({tag, ".retired"}, WIDTH'(retired_cnt), WIDTH'(m_cnt % (1 << CNT_W)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
        rst = 1'b1;
        #1;
        q.delete(); m_cnt = 0; m_sticky = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 4'd6, 128'hF0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 128'hF0, 4'b0000, 4'b0000, 4'd0};
        tbl[1] = '{1'b0, 4'd0, 128'h0,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 128'h0,  4'b0000, 4'b0000, 4'd1};
        tbl[2] = '{1'b1, 4'd1, 128'h1,  4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 128'h1,  4'b0100, 4'b0100, 4'd1};
        tbl[3] = '{1'b1, 4'd2, 128'h2,  4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 128'h1,  4'b0100, 4'b0101, 4'd1};
        tbl[4] = '{1'b1, 4'd3, 128'h3,  4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 128'h1,  4'b0100, 4'b0101, 4'd1};
        tbl[5] = '{1'b1, 4'd3, 128'h3,  4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 128'h2,  4'b0001, 4'b0101, 4'd2};
        tbl[6] = '{1'b1, 4'd3, 128'h3,  4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 128'h2,  4'b0001, 4'b0111, 4'd2};
        tbl[7] = '{1'b0, 4'd0, 128'h0,  4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 128'h3,  4'b0010, 4'b0000, 4'd3};
        tbl[8] = '{1'b1, 4'd4, 128'h4,  4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 128'h4,  4'b1000, 4'b1000, 4'd4};
        tbl[9] = '{1'b0, 4'd0, 128'h0,  4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 128'h0,  4'b0000, 4'b1000, 4'd5};

        // Power-on reset, checked without a clock edge.
        #3 rst = 1'b1;
        #1;
        chk("por.out_valid", WIDTH'(out_valid), WIDTH'(0));
        chk("por.in_ready", WIDTH'(in_ready), WIDTH'(1));
        chk("por.out_result", out_result, '0);
        chk("por.sticky", WIDTH'(sticky_flags), WIDTH'(0));
        chk("por.retired", WIDTH'(retired_cnt), WIDTH'(0));
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: latency, backpressure, sticky clear priority.
        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cycle(tbl[i].iv, tbl[i].op, tbl[i].res, tbl[i].fl, tbl[i].ordy, tbl[i].clr);
            chk({t, ".out_valid"}, WIDTH'(out_valid), WIDTH'(tbl[i].e_valid));
            chk({t, ".in_ready"}, WIDTH'(in_ready), WIDTH'(tbl[i].e_ready));
            chk({t, ".out_opcode"}, WIDTH'(out_opcode), WIDTH'(tbl[i].e_op));
            chk({t, ".out_result"}, out_result, tbl[i].e_res);
            chk({t, ".out_flags"}, WIDTH'(out_flags), WIDTH'(tbl[i].e_fl));
            chk({t, ".sticky"}, WIDTH'(sticky_flags), WIDTH'(tbl[i].e_sticky));
            chk({t, ".retired"}, WIDTH'(retired_cnt), WIDTH'(tbl[i].e_cnt));
        end

        // Mid-stream async reset with two entries held.
        cycle(1'b1, 4'd9, 128'hA, 4'b1111, 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 128'hB, 4'b1111, 1'b0, 1'b0);
        check_model("t1pre");
        #2 rst = 1'b1;
        #1;
        chk("t1.out_valid", WIDTH'(out_valid), WIDTH'(0));
        chk("t1.in_ready", WIDTH'(in_ready), WIDTH'(1));
        chk("t1.out_result", out_result, '0);
        chk("t1.sticky", WIDTH'(sticky_flags), WIDTH'(0));
        chk("t1.retired", WIDTH'(retired_cnt), WIDTH'(0));
        q.delete(); m_cnt = 0; m_sticky = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back push+pop with one entry held: occupancy 1, order kept.
        cycle(1'b1, 4'd1, 128'd1, 4'b0000, 1'b0, 1'b0);
        for (int k = 2; k <= 11; k++) begin
            cycle(1'b1, 4'(k), WIDTH'(k), 4'b0000, 1'b1, 1'b0);
            chk($sformatf("t4.head%0d", k), out_result, WIDTH'(k));
            chk($sformatf("t4.occ%0d", k), WIDTH'({out_valid, in_ready}), WIDTH'(2'b11));
        end
        chk("t4.retired", WIDTH'(retired_cnt), WIDTH'(10));

        // Counter wrap at 2^CNT_W and pointer wrap over many entries.
        do_reset();
        cycle(1'b1, 4'd5, 128'd100, 4'b0000, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            cycle(1'b1, 4'd5, WIDTH'(100 + k), 4'b0000, 1'b1, 1'b0);
            check_model($sformatf("t6.%0d", k));
        end
        chk("t6.retired_wrap", WIDTH'(retired_cnt), WIDTH'(1));
        chk("t6.head", out_result, WIDTH'(117));

        // Randomized traffic against the queue model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom), rnd_word(), 4'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
            check_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
